// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM state encoding and
// the number of stream bytes per instruction word.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int IMEM_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words; word_ready flags the
// accepted byte that completes a word, with word_next holding that word.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_ready
);

    // Only the three most recent bytes are kept; the fourth arrives live.
    logic [23:0] asm_q, asm_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_next  = {asm_q, byte_data};
        word_ready = byte_en && (idx_q == 2'(IMEM_WORD_BYTES - 1));
        asm_d      = asm_q;
        idx_d      = idx_q;
        if (clear) begin
            asm_d = '0;
            idx_d = '0;
        end else if (byte_en) begin
            asm_d = word_next[23:0];
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length byte, then big-endian words,
// optional trailing XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state    | meaning
// ST_IDLE  | out of reset, waiting for start, core held
// ST_LEN   | accepting the word-count byte L
// ST_DATA  | accepting data bytes into the assembler
// ST_WRITE | one-cycle imem write strobe, byte_ready low
// ST_CHECK | accepting the checksum byte (checksum build only)
// ST_DONE  | load succeeded, core released
// ST_ERROR | load failed, core held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORDS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_wraddr,
    output logic [31:0]       imem_wrdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FIN = ST_CHECK;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [7:0]        word_count_q, word_count_d;
    logic              imem_wren_q, imem_wren_d;
    logic [ADDR_W-1:0] imem_wraddr_q, imem_wraddr_d;
    logic [31:0]       imem_wrdata_q, imem_wrdata_d;
    logic              byte_ready_q, byte_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              xfer;
    logic              start_ok;
    logic [31:0]       word_next;
    logic              word_ready;

    assign xfer     = byte_valid && byte_ready_q;
    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                                state_q == ST_ERROR);

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (xfer && state_q == ST_DATA),
        .byte_data  (byte_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        widx_d        = widx_q;
        word_count_d  = word_count_q;
        imem_wren_d   = 1'b0;
        imem_wraddr_d = imem_wraddr_q;
        imem_wrdata_d = imem_wrdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_LEN;
                    word_count_d = '0;
                    widx_d       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    len_d = byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = byte_data;
`endif
                    if (byte_data == 8'd0)
                        state_d = ST_FIN;
                    else if (byte_data > 8'(WORDS))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (word_ready) begin
                        state_d       = ST_WRITE;
                        imem_wren_d   = 1'b1;
                        imem_wraddr_d = widx_q;
                        imem_wrdata_d = word_next;
                    end
                end
            end
            ST_WRITE: begin
                widx_d       = widx_q + ADDR_W'(1);
                word_count_d = word_count_q + 8'd1;
                state_d      = (word_count_q + 8'd1 == len_q) ? ST_FIN : ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer)
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered decodes of the next state.
        byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) ||
                       (state_d == ST_CHECK);
        busy_d       = byte_ready_d || (state_d == ST_WRITE);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERROR);
        cpu_rst_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            widx_q        <= '0;
            word_count_q  <= '0;
            imem_wren_q   <= 1'b0;
            imem_wraddr_q <= '0;
            imem_wrdata_q <= '0;
            byte_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_rst_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            widx_q        <= widx_d;
            word_count_q  <= word_count_d;
            imem_wren_q   <= imem_wren_d;
            imem_wraddr_q <= imem_wraddr_d;
            imem_wrdata_q <= imem_wrdata_d;
            byte_ready_q  <= byte_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cpu_rst_q     <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign byte_ready  = byte_ready_q;
    assign imem_wren   = imem_wren_q;
    assign imem_wraddr = imem_wraddr_q;
    assign imem_wrdata = imem_wrdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios are added
// when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_wraddr;
    logic [31:0]       imem_wrdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        word_count;

    int total = 0;
    int bad = 0;
    int to_cnt = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_wren   (imem_wren),
        .imem_wraddr (imem_wraddr),
        .imem_wrdata (imem_wrdata),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            wr_addr_q.push_back(imem_wraddr);
            wr_data_q.push_back(imem_wrdata);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) to_cnt++;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({byte_ready, imem_wren, cpu_rst, busy, done, error} !== 6'b0 ||
                word_count !== 8'd0 || imem_wraddr !== 6'd0 || imem_wrdata !== 32'd0) begin
                bad++;
                $display("FAIL reset_outputs cyc%0d: got rdy=%b wren=%b cpu_rst=%b busy=%b done=%b err=%b wc=%h addr=%h data=%h want all 0",
                         i, byte_ready, imem_wren, cpu_rst, busy, done, error, word_count, imem_wraddr, imem_wrdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stream(input bit toggle);
        logic [7:0] stream [9];
        int t0;
        stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        t0 = to_cnt;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        total++;
        if (byte_ready !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0 || word_count !== 8'd0) begin
            bad++;
            $display("FAIL after_start t%0d: got rdy=%b busy=%b cpu_rst=%b done=%b wc=%h want 1 1 0 0 00",
                     toggle, byte_ready, busy, cpu_rst, done, word_count);
        end
        for (int i = 0; i < 9; i++) begin
            send_byte(stream[i]);
            if (i == 4 || i == 8) begin
                total++;
                if (imem_wren !== 1'b1 || byte_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL strobe_timing t%0d byte%0d: got wren=%b rdy=%b want 1 0",
                             toggle, i, imem_wren, byte_ready);
                end
                if (i == 4) begin
                    @(posedge clk);
                    #1;
                    total++;
                    if (byte_ready !== 1'b1 || imem_wren !== 1'b0) begin
                        bad++;
                        $display("FAIL ready_after_write t%0d: got rdy=%b wren=%b want 1 0",
                                 toggle, byte_ready, imem_wren);
                    end
                end
            end else if (toggle) begin
                @(posedge clk);
                #1;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h57);
`else
        @(posedge clk);
        #1;
`endif
        total++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || error !== 1'b0 || busy !== 1'b0 ||
            byte_ready !== 1'b0 || word_count !== 8'd2) begin
            bad++;
            $display("FAIL stream_done t%0d: got done=%b cpu_rst=%b err=%b busy=%b rdy=%b wc=%h want 1 1 0 0 0 02",
                     toggle, done, cpu_rst, error, busy, byte_ready, word_count);
        end
        total++;
        if (wr_addr_q.size() !== 2) begin
            bad++;
            $display("FAIL write_count t%0d: got %0d want 2", toggle, wr_addr_q.size());
        end else begin
            total++;
            if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'h20080005) begin
                bad++;
                $display("FAIL word0 t%0d: got @%h=%h want @00=20080005", toggle, wr_addr_q[0], wr_data_q[0]);
            end
            total++;
            if (wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 32'h01095020) begin
                bad++;
                $display("FAIL word1 t%0d: got @%h=%h want @01=01095020", toggle, wr_addr_q[1], wr_data_q[1]);
            end
        end
        total++;
        if (to_cnt !== t0) begin
            bad++;
            $display("FAIL stream_timeout t%0d: got %0d stalls want 0", toggle, to_cnt - t0);
        end
    endtask

    task automatic test_error();
        int t0;
        t0 = to_cnt;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h41);
        total++;
        if (error !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL len_too_big: got err=%b cpu_rst=%b done=%b busy=%b rdy=%b want 1 0 0 0 0",
                     error, cpu_rst, done, busy, byte_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() !== 0 || error !== 1'b1) begin
            bad++;
            $display("FAIL error_no_write: got writes=%0d err=%b want 0 1", wr_addr_q.size(), error);
        end
        pulse_start();
        total++;
        if (error !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_from_error: got err=%b busy=%b rdy=%b want 0 1 1", error, busy, byte_ready);
        end
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        total++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || error !== 1'b0 || word_count !== 8'd0 || wr_addr_q.size() !== 0) begin
            bad++;
            $display("FAIL len_zero: got done=%b cpu_rst=%b err=%b wc=%h writes=%0d want 1 1 0 00 0",
                     done, cpu_rst, error, word_count, wr_addr_q.size());
        end
        total++;
        if (to_cnt !== t0) begin
            bad++;
            $display("FAIL error_timeout: got %0d stalls want 0", to_cnt - t0);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] bytes [7];
        int t0;
        bytes = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        t0 = to_cnt;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(bytes[i]);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({byte_ready, imem_wren, cpu_rst, busy, done, error} !== 6'b0 ||
            word_count !== 8'd0 || imem_wraddr !== 6'd0 || imem_wrdata !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got rdy=%b wren=%b cpu_rst=%b busy=%b done=%b err=%b wc=%h addr=%h data=%h want all 0",
                     byte_ready, imem_wren, cpu_rst, busy, done, error, word_count, imem_wraddr, imem_wrdata);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || imem_wren !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_idle: got busy=%b rdy=%b wren=%b want 0 0 0", busy, byte_ready, imem_wren);
        end
        total++;
        if (wr_addr_q.size() !== 1) begin
            bad++;
            $display("FAIL mid_reset_writes: got %0d want 1", wr_addr_q.size());
        end else begin
            total++;
            if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'h11223344) begin
                bad++;
                $display("FAIL mid_reset_word: got @%h=%h want @00=11223344", wr_addr_q[0], wr_data_q[0]);
            end
        end
        total++;
        if (to_cnt !== t0) begin
            bad++;
            $display("FAIL mid_reset_timeout: got %0d stalls want 0", to_cnt - t0);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bytes [5];
        int t0;
        bytes = '{8'h01, 8'hAA, 8'h55, 8'h0F, 8'hF0};
        t0 = to_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        send_byte(8'h01);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b1 || word_count !== 8'd1) begin
            bad++;
            $display("FAIL csum_match: got done=%b err=%b cpu_rst=%b wc=%h want 1 0 1 01",
                     done, error, cpu_rst, word_count);
        end
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        send_byte(8'h02);
        total++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_rst !== 1'b0) begin
            bad++;
            $display("FAIL csum_mismatch: got done=%b err=%b cpu_rst=%b want 0 1 0", done, error, cpu_rst);
        end
        total++;
        if (to_cnt !== t0) begin
            bad++;
            $display("FAIL csum_timeout: got %0d stalls want 0", to_cnt - t0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_error();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
